// File: rtl/regfile_pkg.sv
// Shared types for the register-file write path.
package regfile_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     value;
  } wb_entry_t;
endpackage

// File: rtl/wb_queue.sv
// In-order circular buffer of pending load results. Entries can be
// invalidated in place by destination register; they keep their slot until popped.
module wb_queue import regfile_pkg::*; #(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH+1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  wb_entry_t             push_entry,
  input  logic                  pop,
  output wb_entry_t             head,
  output logic [CW-1:0]         count,
  input  logic                  kill_en,
  input  logic [REG_ADDR_W-1:0] kill_rd
);
  localparam int AW = $clog2(DEPTH);

  wb_entry_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // The write slot is never occupied, so a push cannot collide with a kill.
      for (int i = 0; i < DEPTH; i++)
        if (kill_en && mem[i].rd == kill_rd) mem[i].valid <= 1'b0;
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head = mem[rd_ptr];
endmodule

// File: rtl/register_writeback.sv
// Single write-port producer: ALU results take priority, loads drain from
// an in-order queue on ALU-idle cycles; younger ALU writes kill older queued loads.
module register_writeback import regfile_pkg::*; #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH+1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [WIDTH-1:0]      alu_value,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [REG_ADDR_W-1:0] ld_rd,
  input  logic [WIDTH-1:0]      ld_value,
  output logic                  write_enable,
  output logic [REG_ADDR_W-1:0] address_write,
  output logic [WIDTH-1:0]      value_write,
  output logic [CW-1:0]         ld_pending
);
  logic      alu_hit, ld_fire, push, pop;
  wb_entry_t push_entry, head;

  assign alu_hit  = alu_valid && (alu_rd != '0);
  assign ld_ready = (ld_pending != CW'(DEPTH));
  assign ld_fire  = ld_valid && ld_ready;
  // x0 loads and loads overwritten by a same-cycle ALU result complete the
  // handshake but never occupy the queue.
  assign push     = ld_fire && (ld_rd != '0) && !(alu_hit && ld_rd == alu_rd);
  assign pop      = !alu_hit && (ld_pending != '0);

  assign push_entry = '{valid: 1'b1, rd: ld_rd, value: DATA_W'(ld_value)};

  wb_queue #(.DEPTH(DEPTH)) u_queue (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .count      (ld_pending),
    .kill_en    (alu_hit),
    .kill_rd    (alu_rd)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_enable  <= 1'b0;
      address_write <= '0;
      value_write   <= '0;
    end else if (alu_hit) begin
      write_enable  <= 1'b1;
      address_write <= alu_rd;
      value_write   <= alu_value;
    end else if (pop) begin
      // A killed head still pops, but emits an idle cycle.
      write_enable <= head.valid;
      if (head.valid) begin
        address_write <= head.rd;
        value_write   <= WIDTH'(head.value);
      end
    end else begin
      write_enable <= 1'b0;
    end
  end
endmodule

// File: tb/tb_register_writeback.sv
// Directed bench for register_writeback with a queue-level reference model
// compared on every falling edge, plus literal checks per scenario.
module tb_register_writeback;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic             clk = 0;
  logic             reset = 0;
  logic             alu_valid = 0;
  logic [4:0]       alu_rd = 0;
  logic [WIDTH-1:0] alu_value = 0;
  logic             ld_valid = 0;
  logic             ld_ready;
  logic [4:0]       ld_rd = 0;
  logic [WIDTH-1:0] ld_value = 0;
  logic             write_enable;
  logic [4:0]       address_write;
  logic [WIDTH-1:0] value_write;
  logic [CW-1:0]    ld_pending;

  int tests = 0;
  int fails = 0;

  register_writeback #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_value(alu_value),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_value(ld_value),
    .write_enable(write_enable), .address_write(address_write),
    .value_write(value_write), .ld_pending(ld_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: program-order list of outstanding loads.
  typedef struct { bit v; logic [4:0] rd; logic [31:0] val; } m_t;
  m_t          mq[$];
  bit          m_we   = 0;
  logic [4:0]  m_addr = 0;
  logic [31:0] m_val  = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_we = 0; m_addr = 0; m_val = 0;
    end else begin
      bit acc, hit;
      m_t e;
      acc = ld_valid && (mq.size() < DEPTH);
      hit = alu_valid && alu_rd != 0;
      if (hit) begin
        foreach (mq[i]) if (mq[i].rd == alu_rd) mq[i].v = 0;
        m_we = 1; m_addr = alu_rd; m_val = alu_value;
      end else if (mq.size() > 0) begin
        e = mq.pop_front();
        m_we = e.v;
        if (e.v) begin m_addr = e.rd; m_val = e.val; end
      end else
        m_we = 0;
      if (acc && ld_rd != 0 && !(hit && ld_rd == alu_rd)) begin
        e.v = 1; e.rd = ld_rd; e.val = ld_value;
        mq.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    chk("model_we",      32'(write_enable), 32'(m_we));
    chk("model_pending", 32'(ld_pending),   32'(mq.size()));
    chk("model_ready",   32'(ld_ready),     32'(mq.size() < DEPTH));
    if (m_we) begin
      chk("model_addr", 32'(address_write), 32'(m_addr));
      chk("model_val",  value_write,        m_val);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    alu_valid = 0; ld_valid = 0;
  endtask

  initial begin
    int acc;
    bit took;

    #1 reset = 1;
    step(); step();
    chk("reset_we",      32'(write_enable), 0);
    chk("reset_ready",   32'(ld_ready),     1);
    chk("reset_pending", 32'(ld_pending),   0);
    chk("reset_addr",    32'(address_write), 0);
    reset = 0;
    step();

    // ALU only: 1-cycle latency, single write.
    alu_valid = 1; alu_rd = 5; alu_value = 32'hDEADBEEF;
    step(); idle();
    chk("alu_we",   32'(write_enable),  1);
    chk("alu_addr", 32'(address_write), 5);
    chk("alu_val",  value_write,        32'hDEADBEEF);
    step();
    chk("alu_we_off",    32'(write_enable),  0);
    chk("alu_addr_hold", 32'(address_write), 5);

    // Load only: accepted, popped next cycle, written the cycle after.
    ld_valid = 1; ld_rd = 7; ld_value = 32'h1234;
    chk("ld_pend0", 32'(ld_pending), 0);
    step(); idle();
    chk("ld_pend1", 32'(ld_pending),   1);
    chk("ld_we_n1", 32'(write_enable), 0);
    step();
    chk("ld_we",    32'(write_enable),  1);
    chk("ld_addr",  32'(address_write), 7);
    chk("ld_val",   value_write,        32'h1234);
    chk("ld_pend2", 32'(ld_pending),    0);
    step();

    // Fill under continuous ALU traffic, then drain in order.
    acc = 0;
    for (int c = 0; c < 20 && acc < 4; c++) begin
      alu_valid = 1; alu_rd = 5'(1 + c % 6); alu_value = 32'(c);
      ld_valid = 1; ld_rd = 5'(10 + acc); ld_value = 32'h100 + 32'(acc);
      took = ld_ready;
      step();
      if (took) acc++;
    end
    chk("fill_accepts", 32'(acc), 4);
    ld_rd = 5'd14; ld_value = 32'h104;
    chk("fill_ready",   32'(ld_ready),   0);
    chk("fill_pending", 32'(ld_pending), 4);
    step();
    chk("fill_ready_held", 32'(ld_ready), 0);
    alu_valid = 0;
    step();
    chk("drain0_we",   32'(write_enable),  1);
    chk("drain0_addr", 32'(address_write), 10);
    chk("drain_ready", 32'(ld_ready),      1);
    step();
    ld_valid = 0;
    for (int j = 1; j < 5; j++) begin
      chk("drain_we",   32'(write_enable),  1);
      chk("drain_addr", 32'(address_write), 32'(10 + j));
      chk("drain_val",  value_write,        32'h100 + 32'(j));
      step();
    end
    chk("drain_done", 32'(ld_pending), 0);
    step();

    // Kill: younger ALU write to the same register drops the queued load.
    alu_valid = 1; alu_rd = 2; alu_value = 32'h22;
    ld_valid = 1; ld_rd = 9; ld_value = 32'hAA;
    step();
    ld_valid = 0; alu_rd = 9; alu_value = 32'hBB;
    step(); idle();
    chk("kill_we",   32'(write_enable),  1);
    chk("kill_addr", 32'(address_write), 9);
    chk("kill_val",  value_write,        32'hBB);
    chk("kill_pend", 32'(ld_pending),    1);
    step();
    chk("kill_pop_we",  32'(write_enable), 0);
    chk("kill_pop_pnd", 32'(ld_pending),   0);
    chk("kill_val_hold", value_write,      32'hBB);
    step();

    // Same-cycle load and ALU to the same register.
    alu_valid = 1; alu_rd = 3; alu_value = 32'h44;
    ld_valid = 1; ld_rd = 3; ld_value = 32'h33;
    step(); idle();
    chk("same_we",   32'(write_enable), 1);
    chk("same_val",  value_write,       32'h44);
    chk("same_pend", 32'(ld_pending),   0);
    step();
    chk("same_we_off", 32'(write_enable), 0);

    // x0 writes from either source are suppressed.
    alu_valid = 1; alu_rd = 0; alu_value = 32'h55;
    ld_valid = 1; ld_rd = 0; ld_value = 32'h66;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("x0_we",   32'(write_enable), 0);
      chk("x0_pend", 32'(ld_pending),   0);
    end
    idle();
    step(); step();
    chk("x0_we_after", 32'(write_enable), 0);

    // Reset mid-operation with three queued loads.
    for (int k = 0; k < 3; k++) begin
      alu_valid = 1; alu_rd = 1; alu_value = 32'(k);
      ld_valid = 1; ld_rd = 5'(20 + k); ld_value = 32'h200 + 32'(k);
      step();
    end
    idle();
    chk("rst_pre_pend", 32'(ld_pending),   3);
    chk("rst_pre_we",   32'(write_enable), 1);
    #2 reset = 1;
    #1;
    chk("rst_async_we",   32'(write_enable),  0);
    chk("rst_async_addr", 32'(address_write), 0);
    chk("rst_async_val",  value_write,        0);
    chk("rst_async_pend", 32'(ld_pending),    0);
    chk("rst_async_rdy",  32'(ld_ready),      1);
    step();
    reset = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("rst_no_stale", 32'(write_enable), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
